// File: rtl/uart_fifo_io.sv
// Memory-mapped full-duplex 8N1 UART with TX/RX FIFOs, programmable divisor and sticky error flags.
// Optional feature macro UART_LOOPBACK_EN: CTRL loopback (bit0) and FIFO flush (bit1).

module uart_fifo_io_fifo #(
   parameter int unsigned DEPTH = 16
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       flush,
   input  logic       push,
   input  logic [7:0] wdata,
   input  logic       pop,
   output logic [7:0] rdata_c,
   output logic       full_c,
   output logic       empty_c
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wp;
   logic [PW-1:0] rp;
   logic          push_ok;
   logic          pop_ok;

   // Boundaries are judged on the pre-update pointers, so a full push or empty pop is dropped.
   assign full_c  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign empty_c = (wp == rp);
   assign push_ok = push && !full_c;
   assign pop_ok  = pop && !empty_c;
   assign rdata_c = mem[rp[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!resetn || flush) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push_ok) wp <= wp + PW'(1);
         if (pop_ok)  rp <= rp + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wp[AW-1:0]] <= wdata;
   end
endmodule

module uart_fifo_io #(
   parameter int unsigned CLK_FREQ_HZ = 50000000,
   parameter int unsigned BAUD_RATE   = 1000000,
   parameter int unsigned TX_DEPTH    = 16,
   parameter int unsigned RX_DEPTH    = 16,
   parameter int unsigned DIV_W       = 16
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        io_sel,
   input  logic [1:0]  io_addr,
   input  logic [31:0] io_wdata,
   input  logic        io_wstrb,
   input  logic        io_rstrb,
   output logic [31:0] io_rdata,
   input  logic        rxd,
   output logic        txd
);
   localparam int unsigned DIV_RST = CLK_FREQ_HZ / BAUD_RATE - 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

   logic             wr_c;
   logic             rd_c;
   logic             tx_push_c;
   logic             tx_pop_c;
   logic             tx_full_c;
   logic             tx_empty_c;
   logic [7:0]       tx_rdata_c;
   logic             rx_push_c;
   logic             rx_pop_c;
   logic             rx_full_c;
   logic             rx_empty_c;
   logic             rx_ferr_c;
   logic [7:0]       rx_rdata_c;
   logic             flush_c;
   logic             rx_in_c;
   logic             loopback;
   logic [31:0]      ctrl_rd_c;
   logic [31:0]      status_c;
   logic [31:0]      rdata_c;
   logic             unused_wdata_c;

   logic [DIV_W-1:0] divisor;
   logic             tx_ovf;
   logic             rx_overrun;
   logic             frame_err;

   uart_state_t      tx_state, tx_state_n;
   logic [DIV_W-1:0] tx_cnt, tx_cnt_n;
   logic [DIV_W-1:0] tx_div, tx_div_n;
   logic [2:0]       tx_bit, tx_bit_n;
   logic [7:0]       tx_shift, tx_shift_n;
   logic             tx_line, tx_line_n;

   uart_state_t      rx_state, rx_state_n;
   logic [DIV_W-1:0] rx_cnt, rx_cnt_n;
   logic [DIV_W-1:0] rx_div, rx_div_n;
   logic [2:0]       rx_bit, rx_bit_n;
   logic [7:0]       rx_shift, rx_shift_n;
   logic             rx_meta;
   logic             rx_s;
   logic             rx_prev;

   assign wr_c           = io_sel && io_wstrb;
   assign rd_c           = io_sel && io_rstrb;
   assign tx_push_c      = wr_c && (io_addr == 2'd0);
   assign rx_pop_c       = rd_c && (io_addr == 2'd0);
   assign unused_wdata_c = ^io_wdata;

`ifdef UART_LOOPBACK_EN
   always_ff @(posedge clk) begin
      if (!resetn)                         loopback <= 1'b0;
      else if (wr_c && io_addr == 2'd3)    loopback <= io_wdata[0];
   end
   assign flush_c   = wr_c && (io_addr == 2'd3) && io_wdata[1];
   assign rx_in_c   = loopback ? tx_line : rxd;
   assign ctrl_rd_c = {31'b0, loopback};
`else
   assign loopback  = 1'b0;
   assign flush_c   = 1'b0;
   assign rx_in_c   = rxd;
   assign ctrl_rd_c = '0;
`endif

   uart_fifo_io_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk(clk), .resetn(resetn), .flush(flush_c),
      .push(tx_push_c), .wdata(io_wdata[7:0]), .pop(tx_pop_c),
      .rdata_c(tx_rdata_c), .full_c(tx_full_c), .empty_c(tx_empty_c)
   );

   uart_fifo_io_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk(clk), .resetn(resetn), .flush(flush_c),
      .push(rx_push_c), .wdata(rx_shift), .pop(rx_pop_c),
      .rdata_c(rx_rdata_c), .full_c(rx_full_c), .empty_c(rx_empty_c)
   );

   // Divisor and sticky flags; a same-cycle set beats a write-1-to-clear.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         divisor    <= DIV_W'(DIV_RST);
         tx_ovf     <= 1'b0;
         rx_overrun <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         if (wr_c && io_addr == 2'd2) divisor <= DIV_W'(io_wdata);
         if (wr_c && io_addr == 2'd1) begin
            if (io_wdata[5]) rx_overrun <= 1'b0;
            if (io_wdata[6]) frame_err  <= 1'b0;
            if (io_wdata[7]) tx_ovf     <= 1'b0;
         end
         if (tx_push_c && tx_full_c) tx_ovf     <= 1'b1;
         if (rx_push_c && rx_full_c) rx_overrun <= 1'b1;
         if (rx_ferr_c)              frame_err  <= 1'b1;
      end
   end

   assign status_c = {22'b0, tx_full_c, 1'b0, tx_ovf, frame_err, rx_overrun,
                      (tx_state != S_IDLE) || !tx_empty_c,
                      rx_full_c, rx_empty_c, tx_empty_c, tx_full_c};

   always_comb begin
      rdata_c = '0;
      case (io_addr)
         2'd0:    rdata_c = rx_empty_c ? 32'b0 : {23'b0, 1'b1, rx_rdata_c};
         2'd1:    rdata_c = status_c;
         2'd2:    rdata_c = 32'(divisor);
         2'd3:    rdata_c = ctrl_rd_c;
         default: rdata_c = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn)   io_rdata <= '0;
      else if (rd_c) io_rdata <= rdata_c;
   end

   // TX: the divisor is latched when a frame starts so a mid-frame write cannot stretch it.
   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_div_n   = tx_div;
      tx_bit_n   = tx_bit;
      tx_shift_n = tx_shift;
      tx_pop_c   = 1'b0;
      case (tx_state)
         S_IDLE: begin
            if (!tx_empty_c) begin
               tx_pop_c   = 1'b1;
               tx_state_n = S_START;
               tx_cnt_n   = '0;
               tx_div_n   = divisor;
               tx_shift_n = tx_rdata_c;
            end
         end
         S_START: begin
            if (tx_cnt == tx_div) begin
               tx_state_n = S_DATA;
               tx_cnt_n   = '0;
               tx_bit_n   = '0;
            end else begin
               tx_cnt_n = tx_cnt + DIV_W'(1);
            end
         end
         S_DATA: begin
            if (tx_cnt == tx_div) begin
               tx_cnt_n   = '0;
               tx_shift_n = {1'b0, tx_shift[7:1]};
               if (tx_bit == 3'd7) tx_state_n = S_STOP;
               else                tx_bit_n   = tx_bit + 3'd1;
            end else begin
               tx_cnt_n = tx_cnt + DIV_W'(1);
            end
         end
         S_STOP: begin
            if (tx_cnt == tx_div) begin
               tx_cnt_n = '0;
               if (!tx_empty_c) begin
                  tx_pop_c   = 1'b1;
                  tx_state_n = S_START;
                  tx_div_n   = divisor;
                  tx_shift_n = tx_rdata_c;
               end else begin
                  tx_state_n = S_IDLE;
               end
            end else begin
               tx_cnt_n = tx_cnt + DIV_W'(1);
            end
         end
         default: tx_state_n = S_IDLE;
      endcase
      tx_line_n = (tx_state_n == S_START) ? 1'b0 :
                  (tx_state_n == S_DATA)  ? tx_shift_n[0] : 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         tx_state <= S_IDLE;
         tx_cnt   <= '0;
         tx_div   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx_line  <= 1'b1;
         txd      <= 1'b1;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_div   <= tx_div_n;
         tx_bit   <= tx_bit_n;
         tx_shift <= tx_shift_n;
         tx_line  <= tx_line_n;
         txd      <= loopback ? 1'b1 : tx_line_n;
      end
   end

   // RX input synchronizer plus one stage of history for falling-edge detection.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx_in_c;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   // RX: start bit is checked at half a period, every later sample one full period on.
   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt;
      rx_div_n   = rx_div;
      rx_bit_n   = rx_bit;
      rx_shift_n = rx_shift;
      rx_push_c  = 1'b0;
      rx_ferr_c  = 1'b0;
      case (rx_state)
         S_IDLE: begin
            if (rx_prev && !rx_s) begin
               rx_state_n = S_START;
               rx_cnt_n   = '0;
               rx_div_n   = divisor;
            end
         end
         S_START: begin
            if (rx_cnt == (rx_div >> 1)) begin
               rx_cnt_n   = '0;
               rx_bit_n   = '0;
               rx_state_n = rx_s ? S_IDLE : S_DATA;
            end else begin
               rx_cnt_n = rx_cnt + DIV_W'(1);
            end
         end
         S_DATA: begin
            if (rx_cnt == rx_div) begin
               rx_cnt_n   = '0;
               rx_shift_n = {rx_s, rx_shift[7:1]};
               if (rx_bit == 3'd7) rx_state_n = S_STOP;
               else                rx_bit_n   = rx_bit + 3'd1;
            end else begin
               rx_cnt_n = rx_cnt + DIV_W'(1);
            end
         end
         S_STOP: begin
            if (rx_cnt == rx_div) begin
               rx_cnt_n   = '0;
               rx_state_n = S_IDLE;
               rx_push_c  = rx_s;
               rx_ferr_c  = !rx_s;
            end else begin
               rx_cnt_n = rx_cnt + DIV_W'(1);
            end
         end
         default: rx_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rx_state <= S_IDLE;
         rx_cnt   <= '0;
         rx_div   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_div   <= rx_div_n;
         rx_bit   <= rx_bit_n;
         rx_shift <= rx_shift_n;
      end
   end
endmodule
